stage_ex: RTL and testbench
===========================

// Module: stage_ex
// PURPOSE
// - MIPS execute stage; consumes the ID/EX latch produced by the decode stage and drives the EX/MEM latch.
// - Selects operands (optionally forwarded), runs the ALU and resolves branches/jumps.
// - Returns isJumped/jumpAddr to the fetch and decode stages so they flush on the same edge.
// PARAMETERS
// - W      32   datapath width
// - RA     5    register address width
// PORTS
// clock             in   1    system clock, all state on posedge
// reset             in   1    synchronous, active-high
// stall             in   1    hold EX/MEM latch, suppress isJumped
// pc_ex             in   32   PC+4 of the instruction in EX
// aluOp             in   4    ALU op; 4'b1111 = R-type, use funct
// isJump            in   1    instruction is branch/jump
// isNotConditional  in   1    unconditional transfer
// isEq              in   1    1 = BEQ sense, 0 = BNE sense
// memWrite, memRead in   1    memory controls, passed through
// wbi               in   2    writeback select, passed through
// aluSrc            in   1    1 = operand B is extendedInstr
// regDst            in   1    1 = dest regAddr2 (rd), 0 = regAddr1 (rt)
// memdatasize       in   2    access size, passed through
// nop               in   1    bubble marker
// reg1, reg2        in   32   rs / rt register-file values
// extendedInstr     in   32   sign-extended imm; [5:0] = funct, [10:6] = shamt
// rs, regAddr1, regAddr2 in 5 rs, rt, rd addresses
// fwdMemAddr/Data/Write  in 5/32/1  MEM-stage destination (for forwarding)
// fwdWbAddr/Data/Write   in 5/32/1  WB-stage destination (for forwarding)
// isJumped          out  1    combinational: taken & ~nop & ~stall & ~reset
// jumpAddr          out  32   pc_ex + (extendedInstr << 2), combinational
// aluResult_mem, storeData_mem out 32  registered ALU result, rt operand
// writeAddr_mem     out  5    registered destination
// memWrite_mem, memRead_mem, wbi_mem, memdatasize_mem, nop_mem  out  registered pass-through
// BEHAVIOUR
// - Reset (sync, active-high) clears all *_mem outputs to 0, except nop_mem = 1.
// - Latency: 1 cycle ID/EX -> EX/MEM.
// - stall = 1: every *_mem output holds its value.
// - Else: latch the new results; nop input copies to nop_mem.
// - Operand A = reg1 (forwarded); shift ops use shamt for the amount.
// - Operand B = aluSrc ? extendedInstr : reg2 (forwarded).
// - storeData_mem = forwarded reg2.
// - ALU ops: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1001 LUI (B << 16).
// - R-type funct: 100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT,
//   000000 SLL, 000010 SRL, 000011 SRA.
// - Undefined op/funct -> result 0.
// - Arithmetic wraps mod 2^32; no overflow trap.
// - Branch taken = isJump & (isNotConditional | (isEq ? A == B_reg : A != B_reg)).
//   B_reg is always the forwarded reg2, never the immediate.
// - A taken branch flushes IF/ID only; the branch itself proceeds to EX/MEM.
// - nop = 1: isJumped = 0; memWrite_mem, memRead_mem and wbi_mem latch 0.
// - stall and a taken branch in the same cycle: isJumped = 0; it is re-evaluated when the stall drops.
// - reset and stall together: reset wins.
// CONFIGURATION
// - STAGE_EX_FORWARDING_EN defined:
//   - Each operand takes MEM data if fwdMemWrite & fwdMemAddr != 0 & address matches.
//   - Else WB data under the same rule, else the register-file value.
//   - MEM has priority over WB; register 0 is never forwarded.
// - Not defined: operands come straight from reg1/reg2; fwd* inputs are ignored; the hazard unit must stall instead.
// STRUCTURE
// - Shared package/header: ALU op codes, funct codes, ALUOP_RTYPE = 4'b1111.
// - One sub-module: alu_unit (combinational: op, funct, shamt, a, b -> result).
// - Forwarding muxes and the EX/MEM latch stay in stage_ex.
// TESTING
// - ADD R-type: reg1 = 5, reg2 = 7, aluOp = 1111, funct = 100000, rd = 3, regDst = 1
//   -> next edge: aluResult_mem = 12, writeAddr_mem = 3.
// - Forward priority (EN): rs = 4, fwdMem (4, 0x10, 1), fwdWb (4, 0x20, 1), ADD imm 1
//   -> aluResult_mem = 0x11.
//   - Same with fwdMemAddr = 0 -> 0x21.
// - BEQ: pc_ex = 0x100, imm = 3, reg1 = reg2 = 9, isJump = 1, isEq = 1
//   -> isJumped = 1, jumpAddr = 0x10C.
//   - reg2 = 8 -> isJumped = 0.
// - Stall: latch ADD 1 + 1, then stall = 1 with new inputs for 3 cycles
//   -> aluResult_mem stays 2; a branch presented during the stall has isJumped = 0.
// - Reset mid-stream: reset = 1 during valid traffic
//   -> next edge: all *_mem = 0, nop_mem = 1, isJumped = 0.
// - SRA/SLT: reg2 = 0x80000000, shamt = 4 -> 0xF8000000.
//   - SLT with A = -1, B = 1 -> 1.

Source files
------------

// File: rtl/stage_ex_pkg.sv
// ---------------------------------------------------------------------------
// stage_ex_pkg
// Purpose : shared constants for the MIPS execute stage: datapath widths,
//           ALU operation codes (as an enum), R-type funct codes and the
//           aluOp value that selects funct decoding.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package stage_ex_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // ALU operation codes driven by the decode stage on aluOp
    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_XOR     = 4'b0011,
        ALU_SUB     = 4'b0110,
        ALU_SLT     = 4'b0111,
        ALU_LUI     = 4'b1001,
        ALU_NOR     = 4'b1100,
        ALUOP_RTYPE = 4'b1111
    } alu_op_e;

    // R-type funct field values (extendedInstr[5:0])
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

endpackage

// File: rtl/stage_ex_alu.sv
// ---------------------------------------------------------------------------
// alu_unit
// Purpose : combinational MIPS ALU. Decodes aluOp directly, or the funct
//           field when aluOp is ALUOP_RTYPE. Unknown codes yield zero.
//           Arithmetic wraps; there is no overflow trap.
// Ports   : op     [3:0]   ALU operation
//           funct  [5:0]   R-type function field
//           shamt  [4:0]   shift amount for SLL/SRL/SRA
//           a      [W-1:0] operand A (rs)
//           b      [W-1:0] operand B (rt or immediate); shifts act on b
//           result [W-1:0] ALU output
// ---------------------------------------------------------------------------
module alu_unit
    import stage_ex_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]   op,
    input  logic [5:0]   funct,
    input  logic [4:0]   shamt,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result
);

    logic slt_bit;

    assign slt_bit = ($signed(a) < $signed(b));

    // MIPS shifts move rt (operand b) by shamt, not rs
    always_comb begin
        result = '0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_XOR: result = a ^ b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(W-1){1'b0}}, slt_bit};
            ALU_LUI: result = b << 16;
            ALU_NOR: result = ~(a | b);
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: result = a + b;
                    FUNCT_SUB, FUNCT_SUBU: result = a - b;
                    FUNCT_AND:             result = a & b;
                    FUNCT_OR:              result = a | b;
                    FUNCT_XOR:             result = a ^ b;
                    FUNCT_NOR:             result = ~(a | b);
                    FUNCT_SLT:             result = {{(W-1){1'b0}}, slt_bit};
                    FUNCT_SLL:             result = b << shamt;
                    FUNCT_SRL:             result = b >> shamt;
                    FUNCT_SRA:             result = W'($signed(b) >>> shamt);
                    default:               result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/stage_ex.sv
// ---------------------------------------------------------------------------
// stage_ex
// Purpose : MIPS execute stage. Takes the ID/EX latch, selects operands,
//           runs the ALU, resolves branches/jumps and registers the EX/MEM
//           latch (1 cycle latency). isJumped/jumpAddr are combinational so
//           fetch and decode can flush on the same edge.
// Config  : STAGE_EX_FORWARDING_EN - when defined, operands are forwarded
//           from the MEM stage (priority) or WB stage; register 0 is never
//           forwarded. When undefined the fwd* inputs are ignored.
// Ports   : clock, reset (sync, active-high), stall
//           ID/EX : pc_ex, aluOp, isJump, isNotConditional, isEq, memWrite,
//                   memRead, wbi, aluSrc, regDst, memdatasize, nop, reg1,
//                   reg2, extendedInstr, rs, regAddr1 (rt), regAddr2 (rd)
//           fwd   : fwdMemAddr/Data/Write, fwdWbAddr/Data/Write
//           out   : isJumped, jumpAddr (comb); *_mem EX/MEM latch (reg)
// ---------------------------------------------------------------------------
module stage_ex
    import stage_ex_pkg::*;
#(
    parameter int W  = 32,
    parameter int RA = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          stall,
    input  logic [W-1:0]  pc_ex,
    input  logic [3:0]    aluOp,
    input  logic          isJump,
    input  logic          isNotConditional,
    input  logic          isEq,
    input  logic          memWrite,
    input  logic          memRead,
    input  logic [1:0]    wbi,
    input  logic          aluSrc,
    input  logic          regDst,
    input  logic [1:0]    memdatasize,
    input  logic          nop,
    input  logic [W-1:0]  reg1,
    input  logic [W-1:0]  reg2,
    input  logic [W-1:0]  extendedInstr,
    input  logic [RA-1:0] rs,
    input  logic [RA-1:0] regAddr1,
    input  logic [RA-1:0] regAddr2,
    input  logic [RA-1:0] fwdMemAddr,
    input  logic [W-1:0]  fwdMemData,
    input  logic          fwdMemWrite,
    input  logic [RA-1:0] fwdWbAddr,
    input  logic [W-1:0]  fwdWbData,
    input  logic          fwdWbWrite,
    output logic          isJumped,
    output logic [W-1:0]  jumpAddr,
    output logic [W-1:0]  aluResult_mem,
    output logic [W-1:0]  storeData_mem,
    output logic [RA-1:0] writeAddr_mem,
    output logic          memWrite_mem,
    output logic          memRead_mem,
    output logic [1:0]    wbi_mem,
    output logic [1:0]    memdatasize_mem,
    output logic          nop_mem
);

    logic [W-1:0] op_a;
    logic [W-1:0] b_reg;
    logic [W-1:0] op_b;
    logic [W-1:0] alu_result;
    logic         taken;

`ifdef STAGE_EX_FORWARDING_EN
    // MEM is younger than WB, so its value wins when both match
    always_comb begin
        op_a = reg1;
        if (fwdMemWrite && fwdMemAddr != '0 && fwdMemAddr == rs)
            op_a = fwdMemData;
        else if (fwdWbWrite && fwdWbAddr != '0 && fwdWbAddr == rs)
            op_a = fwdWbData;
    end

    always_comb begin
        b_reg = reg2;
        if (fwdMemWrite && fwdMemAddr != '0 && fwdMemAddr == regAddr1)
            b_reg = fwdMemData;
        else if (fwdWbWrite && fwdWbAddr != '0 && fwdWbAddr == regAddr1)
            b_reg = fwdWbData;
    end
`else
    // Without forwarding the hazard unit stalls instead; fwd* are ignored
    logic unused_fwd;
    assign unused_fwd = ^{rs, fwdMemAddr, fwdMemData, fwdMemWrite,
                          fwdWbAddr, fwdWbData, fwdWbWrite};
    assign op_a  = reg1;
    assign b_reg = reg2;
`endif

    assign op_b = aluSrc ? extendedInstr : b_reg;

    alu_unit #(.W(W)) u_alu (
        .op     (aluOp),
        .funct  (extendedInstr[5:0]),
        .shamt  (extendedInstr[10:6]),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result)
    );

    // Branch comparison always uses the register operand, never the immediate
    assign taken    = isJump & (isNotConditional |
                                (isEq ? (op_a == b_reg) : (op_a != b_reg)));
    assign isJumped = taken & ~nop & ~stall & ~reset;
    assign jumpAddr = pc_ex + (extendedInstr << 2);

    // EX/MEM latch: reset beats stall; a bubble never carries side effects
    always_ff @(posedge clock) begin
        if (reset) begin
            aluResult_mem   <= '0;
            storeData_mem   <= '0;
            writeAddr_mem   <= '0;
            memWrite_mem    <= 1'b0;
            memRead_mem     <= 1'b0;
            wbi_mem         <= '0;
            memdatasize_mem <= '0;
            nop_mem         <= 1'b1;
        end else if (!stall) begin
            aluResult_mem   <= alu_result;
            storeData_mem   <= b_reg;
            writeAddr_mem   <= regDst ? regAddr2 : regAddr1;
            memWrite_mem    <= memWrite & ~nop;
            memRead_mem     <= memRead & ~nop;
            wbi_mem         <= nop ? 2'b00 : wbi;
            memdatasize_mem <= memdatasize;
            nop_mem         <= nop;
        end
    end

endmodule

// File: tb/tb_stage_ex.sv
// ---------------------------------------------------------------------------
// tb_stage_ex
// Purpose : directed self-checking bench for stage_ex. Each task drives one
//           scenario and compares DUT outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_stage_ex;

    logic        clock;
    logic        reset;
    logic        stall;
    logic [31:0] pc_ex;
    logic [3:0]  aluOp;
    logic        isJump;
    logic        isNotConditional;
    logic        isEq;
    logic        memWrite;
    logic        memRead;
    logic [1:0]  wbi;
    logic        aluSrc;
    logic        regDst;
    logic [1:0]  memdatasize;
    logic        nop;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] extendedInstr;
    logic [4:0]  rs;
    logic [4:0]  regAddr1;
    logic [4:0]  regAddr2;
    logic [4:0]  fwdMemAddr;
    logic [31:0] fwdMemData;
    logic        fwdMemWrite;
    logic [4:0]  fwdWbAddr;
    logic [31:0] fwdWbData;
    logic        fwdWbWrite;
    logic        isJumped;
    logic [31:0] jumpAddr;
    logic [31:0] aluResult_mem;
    logic [31:0] storeData_mem;
    logic [4:0]  writeAddr_mem;
    logic        memWrite_mem;
    logic        memRead_mem;
    logic [1:0]  wbi_mem;
    logic [1:0]  memdatasize_mem;
    logic        nop_mem;

    int checks = 0;
    int errors = 0;

    stage_ex dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .pc_ex            (pc_ex),
        .aluOp            (aluOp),
        .isJump           (isJump),
        .isNotConditional (isNotConditional),
        .isEq             (isEq),
        .memWrite         (memWrite),
        .memRead          (memRead),
        .wbi              (wbi),
        .aluSrc           (aluSrc),
        .regDst           (regDst),
        .memdatasize      (memdatasize),
        .nop              (nop),
        .reg1             (reg1),
        .reg2             (reg2),
        .extendedInstr    (extendedInstr),
        .rs               (rs),
        .regAddr1         (regAddr1),
        .regAddr2         (regAddr2),
        .fwdMemAddr       (fwdMemAddr),
        .fwdMemData       (fwdMemData),
        .fwdMemWrite      (fwdMemWrite),
        .fwdWbAddr        (fwdWbAddr),
        .fwdWbData        (fwdWbData),
        .fwdWbWrite       (fwdWbWrite),
        .isJumped         (isJumped),
        .jumpAddr         (jumpAddr),
        .aluResult_mem    (aluResult_mem),
        .storeData_mem    (storeData_mem),
        .writeAddr_mem    (writeAddr_mem),
        .memWrite_mem     (memWrite_mem),
        .memRead_mem      (memRead_mem),
        .wbi_mem          (wbi_mem),
        .memdatasize_mem  (memdatasize_mem),
        .nop_mem          (nop_mem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Put every ID/EX input into a quiet, non-branching state
    task automatic clear_inputs();
        reset = 0; stall = 0; pc_ex = 0; aluOp = 4'b0010;
        isJump = 0; isNotConditional = 0; isEq = 0;
        memWrite = 0; memRead = 0; wbi = 0; aluSrc = 0; regDst = 0;
        memdatasize = 0; nop = 0; reg1 = 0; reg2 = 0; extendedInstr = 0;
        rs = 0; regAddr1 = 0; regAddr2 = 0;
        fwdMemAddr = 0; fwdMemData = 0; fwdMemWrite = 0;
        fwdWbAddr = 0; fwdWbData = 0; fwdWbWrite = 0;
    endtask

    // Advance one clock and settle away from the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        checks++;
        if (aluResult_mem !== 32'h0 || writeAddr_mem !== 5'h0 || memWrite_mem !== 1'b0 ||
            wbi_mem !== 2'b00 || nop_mem !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_state: alu=%h wa=%h mw=%b wbi=%b nop=%b, required alu=0 wa=0 mw=0 wbi=0 nop=1",
                     aluResult_mem, writeAddr_mem, memWrite_mem, wbi_mem, nop_mem);
        end
        reset = 0;
    endtask

    task automatic test_add_rtype();
        clear_inputs();
        reg1 = 5; reg2 = 7; aluOp = 4'b1111; extendedInstr = 32'h0000_0020;
        regAddr1 = 9; regAddr2 = 3; regDst = 1; wbi = 2'b01; memdatasize = 2'b10;
        step();
        checks++;
        if (aluResult_mem !== 32'd12) begin
            errors++;
            $display("[TB] FAIL add_rtype_result: got %h, required %h", aluResult_mem, 32'd12);
        end
        checks++;
        if (writeAddr_mem !== 5'd3 || storeData_mem !== 32'd7 || wbi_mem !== 2'b01 ||
            memdatasize_mem !== 2'b10 || nop_mem !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_rtype_fields: wa=%0d sd=%h wbi=%b sz=%b nop=%b, required wa=3 sd=7 wbi=01 sz=10 nop=0",
                     writeAddr_mem, storeData_mem, wbi_mem, memdatasize_mem, nop_mem);
        end
        // regDst = 0 selects rt
        regDst = 0;
        step();
        checks++;
        if (writeAddr_mem !== 5'd9) begin
            errors++;
            $display("[TB] FAIL regdst_rt: got %0d, required 9", writeAddr_mem);
        end
    endtask

    task automatic test_alu_ops();
        clear_inputs();
        // SUB 3 - 5 wraps
        aluOp = 4'b0110; reg1 = 3; reg2 = 5;
        step();
        checks++;
        if (aluResult_mem !== 32'hFFFF_FFFE) begin
            errors++;
            $display("[TB] FAIL sub_wrap: got %h, required fffffffe", aluResult_mem);
        end
        // LUI immediate 0x1234
        aluOp = 4'b1001; aluSrc = 1; extendedInstr = 32'h0000_1234;
        step();
        checks++;
        if (aluResult_mem !== 32'h1234_0000) begin
            errors++;
            $display("[TB] FAIL lui: got %h, required 12340000", aluResult_mem);
        end
        // NOR 0xF0F0F0F0 with 0x0F0F0000
        aluOp = 4'b1100; aluSrc = 0; reg1 = 32'hF0F0_F0F0; reg2 = 32'h0F0F_0000;
        step();
        checks++;
        if (aluResult_mem !== 32'h0000_0F0F) begin
            errors++;
            $display("[TB] FAIL nor: got %h, required 00000f0f", aluResult_mem);
        end
        // undefined aluOp gives zero
        aluOp = 4'b0101;
        step();
        checks++;
        if (aluResult_mem !== 32'h0) begin
            errors++;
            $display("[TB] FAIL undef_op: got %h, required 0", aluResult_mem);
        end
    endtask

    task automatic test_sra_slt();
        clear_inputs();
        aluOp = 4'b1111; reg2 = 32'h8000_0000; extendedInstr = 32'h0000_0103;
        step();
        checks++;
        if (aluResult_mem !== 32'hF800_0000) begin
            errors++;
            $display("[TB] FAIL sra: got %h, required f8000000", aluResult_mem);
        end
        // SRL of the same value is logical
        extendedInstr = 32'h0000_0102;
        step();
        checks++;
        if (aluResult_mem !== 32'h0800_0000) begin
            errors++;
            $display("[TB] FAIL srl: got %h, required 08000000", aluResult_mem);
        end
        aluOp = 4'b0111; reg1 = 32'hFFFF_FFFF; reg2 = 32'h1; extendedInstr = 0;
        step();
        checks++;
        if (aluResult_mem !== 32'h1) begin
            errors++;
            $display("[TB] FAIL slt_signed: got %h, required 1", aluResult_mem);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        aluOp = 4'b0010; aluSrc = 1; extendedInstr = 32'h1; rs = 4; reg1 = 32'h5;
        fwdMemAddr = 4; fwdMemData = 32'h10; fwdMemWrite = 1;
        fwdWbAddr = 4; fwdWbData = 32'h20; fwdWbWrite = 1;
        step();
`ifdef STAGE_EX_FORWARDING_EN
        checks++;
        if (aluResult_mem !== 32'h11) begin
            errors++;
            $display("[TB] FAIL fwd_mem_priority: got %h, required 11", aluResult_mem);
        end
        fwdMemAddr = 0;
        step();
        checks++;
        if (aluResult_mem !== 32'h21) begin
            errors++;
            $display("[TB] FAIL fwd_wb: got %h, required 21", aluResult_mem);
        end
`else
        checks++;
        if (aluResult_mem !== 32'h6) begin
            errors++;
            $display("[TB] FAIL fwd_ignored: got %h, required 6", aluResult_mem);
        end
`endif
    endtask

    task automatic test_branch();
        clear_inputs();
        pc_ex = 32'h100; extendedInstr = 32'h3; reg1 = 9; reg2 = 9;
        isJump = 1; isEq = 1; aluSrc = 1;
        #1;
        checks++;
        if (isJumped !== 1'b1 || jumpAddr !== 32'h10C) begin
            errors++;
            $display("[TB] FAIL beq_taken: isJumped=%b addr=%h, required 1 0000010c", isJumped, jumpAddr);
        end
        reg2 = 8;
        #1;
        checks++;
        if (isJumped !== 1'b0) begin
            errors++;
            $display("[TB] FAIL beq_not_taken: got %b, required 0", isJumped);
        end
        isEq = 0;
        #1;
        checks++;
        if (isJumped !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bne_taken: got %b, required 1", isJumped);
        end
        nop = 1;
        #1;
        checks++;
        if (isJumped !== 1'b0) begin
            errors++;
            $display("[TB] FAIL branch_nop: got %b, required 0", isJumped);
        end
        nop = 0; isEq = 1; isNotConditional = 1;
        #1;
        checks++;
        if (isJumped !== 1'b1) begin
            errors++;
            $display("[TB] FAIL uncond_jump: got %b, required 1", isJumped);
        end
        step();
    endtask

    task automatic test_nop();
        clear_inputs();
        nop = 1; memWrite = 1; memRead = 1; wbi = 2'b11; memdatasize = 2'b01;
        step();
        checks++;
        if (memWrite_mem !== 1'b0 || memRead_mem !== 1'b0 || wbi_mem !== 2'b00 ||
            nop_mem !== 1'b1 || memdatasize_mem !== 2'b01) begin
            errors++;
            $display("[TB] FAIL nop_bubble: mw=%b mr=%b wbi=%b nop=%b sz=%b, required 0 0 00 1 01",
                     memWrite_mem, memRead_mem, wbi_mem, nop_mem, memdatasize_mem);
        end
        nop = 0;
        step();
        checks++;
        if (memWrite_mem !== 1'b1 || memRead_mem !== 1'b1 || wbi_mem !== 2'b11 || nop_mem !== 1'b0) begin
            errors++;
            $display("[TB] FAIL valid_controls: mw=%b mr=%b wbi=%b nop=%b, required 1 1 11 0",
                     memWrite_mem, memRead_mem, wbi_mem, nop_mem);
        end
    endtask

    task automatic test_stall();
        clear_inputs();
        aluOp = 4'b0010; aluSrc = 1; reg1 = 1; extendedInstr = 32'h1;
        step();
        stall = 1; reg1 = 50; pc_ex = 32'h200; isJump = 1; isNotConditional = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (isJumped !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_jump_suppressed[%0d]: got %b, required 0", i, isJumped);
            end
            step();
            checks++;
            if (aluResult_mem !== 32'd2) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: got %h, required 2", i, aluResult_mem);
            end
        end
        stall = 0;
        #1;
        checks++;
        if (isJumped !== 1'b1 || jumpAddr !== 32'h204) begin
            errors++;
            $display("[TB] FAIL stall_release_jump: isJumped=%b addr=%h, required 1 00000204", isJumped, jumpAddr);
        end
        step();
        checks++;
        if (aluResult_mem !== 32'd51) begin
            errors++;
            $display("[TB] FAIL stall_release_latch: got %h, required 33", aluResult_mem);
        end
    endtask

    task automatic test_reset_midstream();
        clear_inputs();
        aluOp = 4'b0010; reg1 = 32'hAA; reg2 = 32'h11; regAddr1 = 7;
        memWrite = 1; memRead = 1; wbi = 2'b10; memdatasize = 2'b11;
        step();
        reset = 1; stall = 1; isJump = 1; isNotConditional = 1;
        #1;
        checks++;
        if (isJumped !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_jump_suppressed: got %b, required 0", isJumped);
        end
        step();
        checks++;
        if (aluResult_mem !== 32'h0 || storeData_mem !== 32'h0 || writeAddr_mem !== 5'h0 ||
            memWrite_mem !== 1'b0 || memRead_mem !== 1'b0 || wbi_mem !== 2'b00 ||
            memdatasize_mem !== 2'b00 || nop_mem !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_midstream: alu=%h sd=%h wa=%h mw=%b mr=%b wbi=%b sz=%b nop=%b, required all 0 nop=1",
                     aluResult_mem, storeData_mem, writeAddr_mem, memWrite_mem, memRead_mem,
                     wbi_mem, memdatasize_mem, nop_mem);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_add_rtype();
        test_alu_ops();
        test_sra_slt();
        test_forwarding();
        test_branch();
        test_nop();
        test_stall();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
